alu_share_arbiter: RTL and testbench

//  Shares one ALU between NUM_REQ requesters (e.g. core datapath, address-gen, debug unit).

---
 rtl/alu_share_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter that lends a single external ALU to
// NUM_REQ requesters. It handshakes with each requester, drives and holds the
// ALU operands, waits ALU_LAT cycles, then registers the result together with
// the owning requester's ID.
// Optional feature: define ALU_ARB_FLAGS_EN to add registered resp_zero /
// resp_neg flag outputs alongside resp_data.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 0,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_ctrl,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_ctrl,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [IDW-1:0]           resp_id,
    output logic [WIDTH-1:0]         resp_data
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic                     resp_zero,
    output logic                     resp_neg
`endif
);

    localparam int CNTW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_owner;
    logic [CNTW-1:0]    r_lat_cnt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [2:0]         r_alu_ctrl;
    logic               r_resp_valid;
    logic [IDW-1:0]     r_resp_id;
    logic [WIDTH-1:0]   r_resp_data;

    logic               w_grant_found;
    logic [IDW-1:0]     w_grant;
    logic [IDW-1:0]     w_rr_next;
    logic               w_accept;
    logic               w_lat_done;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [2:0]         w_sel_ctrl;

    // Round-robin search: first valid requester at or above rr_ptr, else wrap to the lowest.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_grant_found = 1'b0;
        w_grant       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_grant_found && req_valid[i] && (IDW'(i) >= r_rr_ptr)) begin
                w_grant_found = 1'b1;
                w_grant       = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_grant_found && req_valid[i]) begin
                w_grant_found = 1'b1;
                w_grant       = IDW'(i);
            end
        end
    end

    // Operand mux for the granted requester and the wrapped next pointer.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_ctrl = 3'b000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_a    = req_a[i*WIDTH +: WIDTH];
                w_sel_b    = req_b[i*WIDTH +: WIDTH];
                w_sel_ctrl = req_ctrl[i*3 +: 3];
            end
        end
        w_rr_next = (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
    end

    assign w_accept   = (r_state == S_IDLE) && w_grant_found;
    assign w_lat_done = (r_lat_cnt == CNTW'(ALU_LAT));

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_grant_found) w_next_state = S_EXEC;
            S_EXEC:  if (w_lat_done)    w_next_state = S_RESP;
            S_RESP:  if (resp_ready)    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: ready only to the granted requester, and only while idle.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && (w_grant == IDW'(i));
        end
    end

    // Datapath: operand capture, latency count and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_lat_cnt    <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= 3'b000;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a    <= w_sel_a;
                        r_alu_b    <= w_sel_b;
                        r_alu_ctrl <= w_sel_ctrl;
                        r_owner    <= w_grant;
                        r_rr_ptr   <= w_rr_next;
                        r_lat_cnt  <= '0;
                    end
                end
                S_EXEC: begin
                    if (w_lat_done) begin
                        r_resp_data  <= alu_result;
                        r_resp_id    <= r_owner;
                        r_resp_valid <= 1'b1;
                        r_lat_cnt    <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) r_resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_ctrl   = r_alu_ctrl;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;

`ifdef ALU_ARB_FLAGS_EN
    logic r_resp_zero;
    logic r_resp_neg;

    // Result flags captured on the same edge as resp_data and held with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_resp_zero <= 1'b0;
            r_resp_neg  <= 1'b0;
        end else if ((r_state == S_EXEC) && w_lat_done) begin
            r_resp_zero <= (alu_result == '0);
            r_resp_neg  <= alu_result[WIDTH-1];
        end
    end

    assign resp_zero = r_resp_zero;
    assign resp_neg  = r_resp_neg;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: two instances (ALU_LAT=0 and ALU_LAT=2), each
// with its own ALU model. Stimulus pushes expected responses into a per-instance
// queue at each handshake; a per-instance monitor pops and compares responses.
// Define ALU_ARB_FLAGS_EN to also check resp_zero / resp_neg.
module tb_alu_share_arbiter;

    localparam int NR = 2;
    localparam int W  = 32;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      req_valid  [2];
    logic [1:0]      req_ready  [2];
    logic [63:0]     req_a      [2];
    logic [63:0]     req_b      [2];
    logic [5:0]      req_ctrl   [2];
    logic [31:0]     alu_a      [2];
    logic [31:0]     alu_b      [2];
    logic [2:0]      alu_ctrl   [2];
    logic [31:0]     alu_result [2];
    logic            resp_valid [2];
    logic            resp_ready [2];
    logic            resp_id    [2];
    logic [31:0]     resp_data  [2];
`ifdef ALU_ARB_FLAGS_EN
    logic            resp_zero  [2];
    logic            resp_neg   [2];
`endif

    exp_t            exp_q [2][$];
    logic [31:0]     exp_res  [2][2];
    logic            mrr      [2];
    logic            hold     [2];
    logic            pid      [2];
    logic [31:0]     pdata    [2];
    int              xfer_cnt [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_share_arbiter #(
            .NUM_REQ (NR),
            .WIDTH   (W),
            .ALU_LAT (2 * g)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_a      (req_a[g]),
            .req_b      (req_b[g]),
            .req_ctrl   (req_ctrl[g]),
            .alu_a      (alu_a[g]),
            .alu_b      (alu_b[g]),
            .alu_ctrl   (alu_ctrl[g]),
            .alu_result (alu_result[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_id    (resp_id[g]),
            .resp_data  (resp_data[g])
`ifdef ALU_ARB_FLAGS_EN
            ,
            .resp_zero  (resp_zero[g]),
            .resp_neg   (resp_neg[g])
`endif
        );

        if (g == 0) begin : g_alu_comb
            assign alu_result[g] = alu_f(alu_a[g], alu_b[g], alu_ctrl[g]);
        end else begin : g_alu_pipe
            logic [31:0] p1, p2;
            always @(posedge clk) begin
                p1 <= alu_f(alu_a[g], alu_b[g], alu_ctrl[g]);
                p2 <= p1;
            end
            assign alu_result[g] = p2;
        end

        // Monitor: grant model, handshake scoreboard push, response pop/compare, hold stability.
        always @(negedge clk) begin : mon
            exp_t       e;
            logic [1:0] eg;
            if (!rst) begin
                exp_q[g].delete();
                mrr[g]  = 1'b0;
                hold[g] = 1'b0;
            end else begin
                if (hold[g]) begin
                    check("hold_valid", 32'(resp_valid[g]), 32'd1);
                    check("hold_id",    32'(resp_id[g]),    32'(pid[g]));
                    check("hold_data",  resp_data[g],       pdata[g]);
                end
                if (resp_valid[g]) check("ready_in_resp", 32'(req_ready[g]), 32'd0);
                if (req_ready[g] != 2'b00) begin
                    if (req_valid[g][mrr[g]]) eg = 2'b01 << mrr[g];
                    else                      eg = 2'b01 << (~mrr[g]);
                    check("grant", 32'(req_ready[g]), 32'(eg));
                    for (int r = 0; r < 2; r++) begin
                        if (req_valid[g][r] && req_ready[g][r]) begin
                            e.id   = r[0];
                            e.data = exp_res[g][r];
                            exp_q[g].push_back(e);
                            mrr[g] = ~r[0];
                            xfer_cnt[g]++;
                        end
                    end
                end
                if (resp_valid[g] && resp_ready[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        check("resp_id",   32'(resp_id[g]), 32'(e.id));
                        check("resp_data", resp_data[g],    e.data);
`ifdef ALU_ARB_FLAGS_EN
                        check("resp_zero", 32'(resp_zero[g]), 32'(e.data == 32'd0));
                        check("resp_neg",  32'(resp_neg[g]),  32'(e.data[31]));
`endif
                    end
                end
                hold[g]  = resp_valid[g] && !resp_ready[g];
                pid[g]   = resp_id[g];
                pdata[g] = resp_data[g];
            end
        end
    end

    task automatic load(input int d, input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic [31:0] e);
        req_a[d][r*32 +: 32]  = a;
        req_b[d][r*32 +: 32]  = b;
        req_ctrl[d][r*3 +: 3] = c;
        exp_res[d][r]         = e;
        req_valid[d][r]       = 1'b1;
    endtask

    // Returns at posedge+1 just after the n-th further transfer edge.
    task automatic wait_xfers(input int d, input int n_more, input int budget);
        int target = xfer_cnt[d] + n_more;
        int n = 0;
        while (xfer_cnt[d] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (xfer_cnt[d] < target) check("xfer_timeout", 32'(xfer_cnt[d]), 32'(target));
        #1;
    endtask

    // Counts negedges after the transfer until resp_valid; checks operands held in EXEC.
    task automatic measure_lat(input int d, input int exp_lat, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!resp_valid[d]) begin
                check("exec_alu_a",    alu_a[d],          a);
                check("exec_alu_b",    alu_b[d],          b);
                check("exec_alu_ctrl", 32'(alu_ctrl[d]),  32'(c));
            end
        end while (!resp_valid[d] && n < 20);
        check("latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (exp_q[d].size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_q[d].size() != 0) check("drain_timeout", 32'(exp_q[d].size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int d, input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, input logic [31:0] e, input int lat);
        load(d, r, a, b, c, e);
        #2;
        check("idle_ready", 32'(req_ready[d]), 32'(2'b01 << r));
        wait_xfers(d, 1, 20);
        req_valid[d][r] = 1'b0;
        measure_lat(d, lat, a, b, c);
        drain(d);
    endtask

    task automatic check_reset(input int d);
        check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
        check("rst_req_ready",  32'(req_ready[d]),  32'd0);
        check("rst_alu_a",      alu_a[d],           32'd0);
        check("rst_alu_b",      alu_b[d],           32'd0);
        check("rst_alu_ctrl",   32'(alu_ctrl[d]),   32'd0);
        check("rst_resp_id",    32'(resp_id[d]),    32'd0);
        check("rst_resp_data",  resp_data[d],       32'd0);
`ifdef ALU_ARB_FLAGS_EN
        check("rst_resp_zero",  32'(resp_zero[d]),  32'd0);
        check("rst_resp_neg",   32'(resp_neg[d]),   32'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = '0;
            req_a[d]      = '0;
            req_b[d]      = '0;
            req_ctrl[d]   = '0;
            resp_ready[d] = 1'b1;
            xfer_cnt[d]   = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single requests on the combinational-ALU instance.
        run_op(0, 0, 32'd5,         32'd3,         3'b000, 32'd8,         2);
        run_op(0, 1, 32'd3,         32'd3,         3'b001, 32'd0,         2);
        run_op(0, 0, 32'd1,         32'd2,         3'b001, 32'hFFFF_FFFF, 2);
        run_op(0, 1, 32'h0000_F0F0, 32'h0000_0FF0, 3'b010, 32'h0000_00F0, 2);
        run_op(0, 0, 32'h0000_F000, 32'h0000_000F, 3'b011, 32'h0000_F00F, 2);
        run_op(0, 1, 32'h8000_0000, 32'd1,         3'b101, 32'd1,         2);
        run_op(0, 0, 32'd5,         32'hFFFF_FFFB, 3'b000, 32'd0,         2);

        // Both requesters held valid from rr_ptr 0: grants must alternate 0,1,0,1.
        do_reset();
        load(0, 0, 32'd1,  32'd1, 3'b000, 32'd2);
        load(0, 1, 32'd10, 32'd3, 3'b001, 32'd7);
        wait_xfers(0, 4, 60);
        req_valid[0] = 2'b00;
        drain(0);

        // Back-pressured response with a second requester waiting.
        resp_ready[0] = 1'b0;
        load(0, 0, 32'd10, 32'd4, 3'b011, 32'd14);
        wait_xfers(0, 1, 20);
        req_valid[0][0] = 1'b0;
        load(0, 1, 32'h0000_00F0, 32'h0000_000F, 3'b010, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_accept_next", 32'(req_ready[0]), 32'd2);
        wait_xfers(0, 1, 10);
        req_valid[0][1] = 1'b0;
        drain(0);

        // Two-cycle ALU instance: latency 4, operands held for all EXEC cycles.
        run_op(1, 0, 32'd7,         32'd9, 3'b001, 32'hFFFF_FFFE, 4);
        run_op(1, 1, 32'hFFFF_FFFF, 32'd1, 3'b101, 32'd1,         4);
        run_op(1, 0, 32'd5,         32'd6, 3'b111, 32'hDEAD_BEEF, 4);

        // Reset during EXEC discards the operation.
        load(1, 1, 32'd20, 32'd22, 3'b000, 32'd42);
        wait_xfers(1, 1, 20);
        req_valid[1][1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset(1);
        check_reset(0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", 32'(resp_valid[1]), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
